// File: rtl/seq_gen_1011.sv
// seq_gen_1011: serial framed-bit transmitter.
// Each word accepted over valid/ready leaves on out_bit as a frame:
// SYNC_LEN sync bits from SYNC_PAT, then DATA_W payload bits (both MSB
// first), then GAP_LEN idle cycles. A new word taken in the final cycle
// of a frame starts the next sync phase with no extra idle cycle.
module seq_gen_1011 #(
  parameter int         DATA_W   = 8,
  parameter logic [7:0] SYNC_PAT = 8'b0000_1011,
  parameter int         SYNC_LEN = 4,
  parameter int         GAP_LEN  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              sync_active,
  output logic              frame_done
);

  // One counter serves every phase, so it is sized for the longest one.
  localparam int MAX_SD  = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
  localparam int MAX_LEN = (MAX_SD > GAP_LEN) ? MAX_SD : GAP_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  // Sync marker left-aligned so the first sync bit sits in bit 7.
  localparam logic [7:0] SYNC_INIT = 8'(SYNC_PAT << (8 - SYNC_LEN));

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  // Counter values one cycle before the final cycle of a frame; only
  // consulted when the corresponding phase is long enough to have one.
  localparam logic [CNT_W-1:0] DATA_PRE  = CNT_W'((DATA_W >= 2) ? DATA_W - 2 : 0);
  localparam logic [CNT_W-1:0] GAP_PRE   = CNT_W'((GAP_LEN >= 2) ? GAP_LEN - 2 : 0);

  // Frame is two cycles long at minimum, so the final cycle can only be
  // the first DATA cycle when both the payload is one bit and there is no gap.
  localparam logic DONE_ON_FIRST_DATA = (GAP_LEN == 0) && (DATA_W == 1);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    GAP
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  shift_q;
  logic [7:0]         sync_q;
  logic               out_bit_q;
  logic               out_valid_q;
  logic               sync_active_q;
  logic               frame_done_q;
  logic               xfer;

  // Ready in IDLE and in the final cycle of a frame, which is exactly
  // when the registered frame_done flag is high.
  assign data_ready = (state_q == IDLE) || frame_done_q;
  assign xfer       = data_valid && data_ready;

  assign out_bit     = out_bit_q;
  assign out_valid   = out_valid_q;
  assign sync_active = sync_active_q;
  assign frame_done  = frame_done_q;

  // Frame sequencer: every output is computed one edge ahead and held
  // in a register, so each state_q describes the cycle being driven.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: all state here is assigned with <= so every register samples
      // the pre-edge values of its neighbours, regardless of statement order.
      state_q       <= IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      sync_q        <= '0;
      out_bit_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      sync_active_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else if (xfer) begin
      // New word: latch it and put the first sync bit on the line.
      state_q       <= SYNC;
      cnt_q         <= '0;
      shift_q       <= data_in;
      sync_q        <= SYNC_INIT << 1;
      out_bit_q     <= SYNC_INIT[7];
      out_valid_q   <= 1'b1;
      sync_active_q <= 1'b1;
      frame_done_q  <= 1'b0;
    end else if (frame_done_q || (state_q == IDLE)) begin
      // Frame finished (or nothing pending) with no new word: go quiet.
      state_q       <= IDLE;
      cnt_q         <= '0;
      out_bit_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      sync_active_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      case (state_q)
        SYNC: begin
          if (cnt_q == SYNC_LAST) begin
            state_q       <= DATA;
            cnt_q         <= '0;
            out_bit_q     <= shift_q[DATA_W-1];
            shift_q       <= shift_q << 1;
            out_valid_q   <= 1'b1;
            sync_active_q <= 1'b0;
            frame_done_q  <= DONE_ON_FIRST_DATA;
          end else begin
            cnt_q         <= cnt_q + CNT_W'(1);
            out_bit_q     <= sync_q[7];
            sync_q        <= sync_q << 1;
          end
        end
        DATA: begin
          if (cnt_q == DATA_LAST) begin
            // Reached only with a non-empty gap; with no gap the last data
            // cycle carries frame_done and the branch above takes over.
            state_q       <= GAP;
            cnt_q         <= '0;
            out_bit_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            sync_active_q <= 1'b0;
            frame_done_q  <= (GAP_LEN == 1);
          end else begin
            cnt_q         <= cnt_q + CNT_W'(1);
            out_bit_q     <= shift_q[DATA_W-1];
            shift_q       <= shift_q << 1;
            frame_done_q  <= (GAP_LEN == 0) && (cnt_q == DATA_PRE);
          end
        end
        GAP: begin
          cnt_q        <= cnt_q + CNT_W'(1);
          frame_done_q <= (cnt_q == GAP_PRE);
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen_1011.sv
// Testbench for seq_gen_1011: a default-parameter instance under directed
// and random traffic, plus a minimal-frame instance (1 sync bit, 1 data
// bit, no gap) fed continuously. A positional frame model predicts every
// output cycle into per-instance scoreboards drained by a monitor.
module tb_seq_gen_1011;

  localparam int         DW  = 8;
  localparam int         SL  = 4;
  localparam int         GL  = 2;
  localparam logic [7:0] PAT = 8'b0000_1011;
  localparam int         P_M = SL + DW + GL;

  localparam int C_DW = 1;
  localparam int C_SL = 1;
  localparam int C_GL = 0;
  localparam int P_C  = C_SL + C_DW + C_GL;

  // Expected view of one output cycle: {out_bit, out_valid, sync_active, frame_done, data_ready}.
  typedef struct packed {
    logic bit_;
    logic valid;
    logic sync;
    logic done;
    logic ready;
  } exp_t;

  localparam exp_t IDLE_E = 5'b00001;

  logic       clk;
  logic       rst_n;
  logic       data_valid;
  logic [7:0] data_in;
  logic       data_ready, out_bit, out_valid, sync_active, frame_done;

  logic       c_data_valid;
  logic [0:0] c_data_in;
  logic       c_data_ready, c_out_bit, c_out_valid, c_sync_active, c_frame_done;

  int   tests  = 0;
  int   failed = 0;
  int   cycle  = 0;
  exp_t sb_m[$];
  exp_t sb_c[$];
  int   pos_m = -1;
  int   pos_c = -1;
  logic [31:0] word_m = '0;
  logic [31:0] word_c = '0;

  seq_gen_1011 dut (
    .clk        (clk),
    .reset      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .sync_active(sync_active),
    .frame_done (frame_done)
  );

  seq_gen_1011 #(
    .DATA_W  (C_DW),
    .SYNC_PAT(PAT),
    .SYNC_LEN(C_SL),
    .GAP_LEN (C_GL)
  ) dut_c (
    .clk        (clk),
    .reset      (rst_n),
    .data_in    (c_data_in),
    .data_valid (c_data_valid),
    .data_ready (c_data_ready),
    .out_bit    (c_out_bit),
    .out_valid  (c_out_valid),
    .sync_active(c_sync_active),
    .frame_done (c_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What a frame shows at position pos (0-based) for a given word.
  function automatic exp_t frame_entry(input int pos, input logic [31:0] word,
                                       input int sl, input int dw, input int gl,
                                       input logic [7:0] pat);
    exp_t e;
    e = '0;
    if (pos < sl) begin
      e.bit_  = pat[sl-1-pos];
      e.valid = 1'b1;
      e.sync  = 1'b1;
    end else if (pos < sl + dw) begin
      e.bit_  = word[dw-1-(pos-sl)];
      e.valid = 1'b1;
    end
    e.done  = (pos == sl + dw + gl - 1);
    e.ready = e.done;
    return e;
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got {bit,valid,sync,done,ready}=%b, expected %b", name, act, exp);
    end
  endtask

  // Reference model: tracks the position inside the current frame and
  // pushes the expected view of the upcoming cycle at each edge.
  initial begin : model
    bit x;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pos_m = -1;
        pos_c = -1;
        sb_m.delete();
        sb_c.delete();
        sb_m.push_back(IDLE_E);
        sb_c.push_back(IDLE_E);
      end else begin
        x = data_valid && (pos_m < 0 || pos_m == P_M - 1);
        if (x) begin
          word_m = 32'(data_in);
          pos_m  = 0;
        end else if (pos_m >= 0) begin
          pos_m = (pos_m == P_M - 1) ? -1 : pos_m + 1;
        end
        sb_m.push_back((pos_m < 0) ? IDLE_E : frame_entry(pos_m, word_m, SL, DW, GL, PAT));

        x = c_data_valid && (pos_c < 0 || pos_c == P_C - 1);
        if (x) begin
          word_c = 32'(c_data_in);
          pos_c  = 0;
        end else if (pos_c >= 0) begin
          pos_c = (pos_c == P_C - 1) ? -1 : pos_c + 1;
        end
        sb_c.push_back((pos_c < 0) ? IDLE_E : frame_entry(pos_c, word_c, C_SL, C_DW, C_GL, PAT));
      end
    end
  end

  // Monitor: one scoreboard entry per instance per cycle, sampled mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cycle++;
      if (sb_m.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL main scoreboard empty at cycle %0d", cycle);
      end else begin
        e = sb_m.pop_front();
        check($sformatf("main cyc %0d", cycle),
              {out_bit, out_valid, sync_active, frame_done, data_ready}, e);
      end
      if (sb_c.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL corner scoreboard empty at cycle %0d", cycle);
      end else begin
        e = sb_c.pop_front();
        check($sformatf("corner cyc %0d", cycle),
              {c_out_bit, c_out_valid, c_sync_active, c_frame_done, c_data_ready}, e);
      end
    end
  end

  // Apply inputs for n rising edges; returns 2 time units after the last.
  task automatic drive(input logic v, input logic [7:0] d, input int n);
    data_valid = v;
    data_in    = d;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_reset_now(input string name);
    check({name, " main"}, {out_bit, out_valid, sync_active, frame_done, data_ready}, IDLE_E);
    check({name, " corner"}, {c_out_bit, c_out_valid, c_sync_active, c_frame_done, c_data_ready}, IDLE_E);
  endtask

  initial begin : stimulus
    rst_n        = 1'b1;
    data_valid   = 1'b1;
    data_in      = 8'h55;
    c_data_valid = 1'b1;
    c_data_in    = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_now("reset at start");
    // Reset held for three edges with data_valid high: nothing is taken.
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single frame, one-cycle pulse.
    drive(1'b1, 8'hA5, 1);
    drive(1'b0, 8'h00, 16);

    // Back-to-back: 3C held through the frame, C3 on the final cycle.
    drive(1'b1, 8'h3C, 14);
    drive(1'b1, 8'hC3, 1);
    drive(1'b0, 8'h00, 18);

    // Stall: valid toggles with junk data while the frame is busy.
    drive(1'b1, 8'h96, 1);
    for (int i = 0; i < 13; i++) drive(i[0], 8'(8'h11 * (i + 1)), 1);
    drive(1'b1, 8'h69, 1);
    drive(1'b0, 8'h00, 18);

    // Reset during the third payload bit of FF.
    drive(1'b1, 8'hFF, 1);
    drive(1'b0, 8'h00, 6);
    #1 rst_n = 1'b0;
    #1 check_reset_now("reset mid-frame");
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1'b1, 8'h0B, 1);
    drive(1'b0, 8'h00, 16);

    // Random traffic, valid biased high.
    for (int i = 0; i < 400; i++) drive($urandom_range(0, 3) != 0, 8'($urandom), 1);
    drive(1'b0, 8'h00, 20);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seq_gen_1011.md
Name: seq_gen_1011

Overview:
- Serial framed-bit transmitter. Source side of the 1011 sequence-detection link.
- Accepts parallel words over a valid/ready handshake.
- Emits each word on a single serial line, MSB first, preceded by the sync marker 1011 and followed by an optional idle gap.
- Feeds the serial input of the downstream 1011 detector and drives its stimulus in system-level loopback.

Parameters:
- DATA_W, 8, payload bits per frame; legal range >= 1.
- SYNC_PAT, 8'b0000_1011, sync marker; the low SYNC_LEN bits are sent MSB first.
- SYNC_LEN, 4, number of sync bits sent; legal range 1..8.
- GAP_LEN, 2, idle cycles after each frame; legal range >= 0.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- reset  input  1  Asynchronous, active-low reset. Asserting it (0) clears all state immediately; release is sampled on clk.
- data_in  input  DATA_W  Payload word. Captured only on the handshake edge.
- data_valid  input  1  Source has a word on data_in.
- data_ready  output  1  Block can accept a word this cycle.
- out_bit  output  1  Serial output bit, registered.
- out_valid  output  1  out_bit carries a sync or payload bit this cycle, registered.
- sync_active  output  1  Current out_bit is a sync bit, registered.
- frame_done  output  1  One-cycle pulse on the final cycle of a frame (gap included).

Behaviour:
- Reset values (while reset=0, asynchronous):
  - state=IDLE; out_bit=0, out_valid=0, sync_active=0, frame_done=0; data_ready=1.
  - Shift register and counters cleared.
- Handshake:
  - Transfer occurs on the rising edge where data_valid && data_ready.
  - data_in is latched into the shift register at that edge; later changes to data_in have no effect.
  - data_valid is not required to stay high after a transfer.
- FSM states: IDLE, SYNC, DATA, GAP.
  - IDLE: data_ready=1, out_valid=0, out_bit=0. On transfer -> SYNC.
  - SYNC: runs SYNC_LEN cycles. out_bit = SYNC_PAT[SYNC_LEN-1-i] on cycle i; out_valid=1; sync_active=1. After the last sync bit -> DATA.
  - DATA: runs DATA_W cycles. out_bit = latched word bit DATA_W-1-j on cycle j; out_valid=1; sync_active=0. After the last bit -> GAP, or -> IDLE/SYNC if GAP_LEN=0.
  - GAP: runs GAP_LEN cycles. out_bit=0, out_valid=0. Then -> IDLE, or -> SYNC if a transfer occurred on the final cycle.
- Latency: the first sync bit appears on out_bit in the cycle right after the transfer edge (registered, one edge).
- Frame period: SYNC_LEN + DATA_W + GAP_LEN cycles.
- data_ready is 1 in IDLE and in the final cycle of a frame; 0 otherwise.
  - A transfer in the final cycle starts the next frame's SYNC with no extra idle cycle, so streaming is gapless apart from GAP_LEN.
- frame_done is 1 exactly in the final cycle of a frame: the last GAP cycle, or the last DATA cycle when GAP_LEN=0.
- data_valid while data_ready=0 is ignored. The word is not captured and no error is raised; the source must hold it.
- Counters are sized for max(SYNC_LEN, DATA_W, GAP_LEN). They must not wrap inside a phase.
- Reset asserted mid-frame:
  - The frame is aborted and outputs return to reset values immediately.
  - The in-flight word is discarded.
  - After release, the block starts in IDLE with data_ready=1.

Test Plan:
- Reset: hold reset=0 for 3 cycles with data_valid=1 -> out_valid=0, out_bit=0, data_ready=1, frame_done=0; no transfer occurs.
- Single frame, defaults, data_in=8'hA5 pulsed for one cycle -> from the next cycle out_bit = 1,0,1,1 (sync_active=1), then 1,0,1,0,0,1,0,1 (out_valid=1), then 2 cycles out_valid=0. frame_done is high only on the 14th cycle; data_ready returns to 1.
- Back-to-back: data_valid held high with 8'h3C then 8'hC3 -> second transfer on the frame_done cycle; the second sync starts exactly 14 cycles after the first; payload bits are 00111100 then 11000011.
- Stall: data_valid toggled while data_ready=0 during a frame -> no capture; payload of the current frame unchanged; next word is accepted only on the final cycle.
- Reset mid-frame: assert reset=0 during the 3rd payload bit of 8'hFF -> outputs clear in the same cycle with no clk edge needed. After release, IDLE; the next word 8'h0B is sent in full, payload 00001011.
- Parameter corner: DATA_W=1, SYNC_LEN=1, GAP_LEN=0, data_valid held with data_in=1 -> continuous out_bit 1,1,1,1 with out_valid=1 every cycle and frame_done high every 2nd cycle.
